dtcm_arbiter: RTL

//  Shares the single DTCM port between NREQ requesters: index 0 = LSU ctrl, index 1 = external/debug master.

---
 rtl/dtcm_arbiter_pkg.sv | 21 ++
 rtl/gnrl_fifo.sv | 55 +++++
 rtl/dtcm_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dtcm_arbiter_pkg.sv
// Shared widths, defaults and the muxed command bundle
// for the DTCM port arbiter.
package dtcm_arbiter_pkg;

  localparam int XLEN            = 32;
  localparam int DTCM_ADDR_WIDTH = 16;
  localparam int DTCM_ARB_NREQ   = 2;
  localparam int DTCM_ARB_OUTS   = 2;

  typedef struct packed {
    logic                       read;
    logic [DTCM_ADDR_WIDTH-1:0] addr;
    logic [XLEN-1:0]            wdata;
    logic [XLEN/8-1:0]          wmask;
  } dtcm_cmd_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gnrl_fifo.sv
// Small synchronous FIFO with occupancy count.
// Push when full and pop when empty are ignored.
module gnrl_fifo #(
  parameter int DW = 1,
  parameter int DP = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic [$clog2(DP+1)-1:0]  count
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push & (count != CW'(DP));
  assign do_pop   = pop & (count != '0);
  assign pop_data = mem[rptr];

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= nxt(wptr);
      if (do_pop)  rptr <= nxt(rptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dtcm_arbiter.sv
// Round-robin arbiter sharing one DTCM port; an in-order
// FIFO of grant indices routes each response back.
module dtcm_arbiter
  import dtcm_arbiter_pkg::*;
#(
  parameter int NREQ       = DTCM_ARB_NREQ,
  parameter int OUTS_DEPTH = DTCM_ARB_OUTS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req_cmd_valid,
  output logic [NREQ-1:0]                 req_cmd_ready,
  input  logic [NREQ-1:0]                 req_cmd_read,
  input  logic [NREQ*DTCM_ADDR_WIDTH-1:0] req_cmd_addr,
  input  logic [NREQ*XLEN-1:0]            req_cmd_wdata,
  input  logic [NREQ*XLEN/8-1:0]          req_cmd_wmask,
  output logic [NREQ-1:0]                 req_rsp_valid,
  output logic [XLEN-1:0]                 req_rsp_rdata,
  output logic                            dtcm_cmd_valid,
  input  logic                            dtcm_cmd_ready,
  output logic                            dtcm_cmd_read,
  output logic [DTCM_ADDR_WIDTH-1:0]      dtcm_cmd_addr,
  output logic [XLEN-1:0]                 dtcm_cmd_wdata,
  output logic [XLEN/8-1:0]               dtcm_cmd_wmask,
  input  logic                            dtcm_rsp_valid,
  output logic                            dtcm_rsp_ready,
  input  logic [XLEN-1:0]                 dtcm_rsp_rdata,
  output logic                            arb_err
);

  localparam int IW = idx_w(NREQ);
  localparam int CW = $clog2(OUTS_DEPTH + 1);
  localparam int AW = DTCM_ADDR_WIDTH;
  localparam int MW = XLEN / 8;

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   head;
  logic [IW-1:0]   j;
  logic [NREQ-1:0] grant;
  logic [CW-1:0]   cnt;
  logic            found;
  logic            can_issue;
  logic            push;
  logic            pop;
  logic            empty;
  dtcm_cmd_t       sel;

  // Slot freed by a pop only becomes usable next cycle.
  assign can_issue = (cnt < CW'(OUTS_DEPTH)) & ~rst;
  assign empty     = (cnt == '0);

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_cmd_valid[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        gidx     = j;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel.read  = req_cmd_read[i];
        sel.addr  = req_cmd_addr[i*AW +: AW];
        sel.wdata = req_cmd_wdata[i*XLEN +: XLEN];
        sel.wmask = req_cmd_wmask[i*MW +: MW];
      end
    end
  end

  assign dtcm_cmd_valid = (|grant) & can_issue;
  assign dtcm_cmd_read  = sel.read;
  assign dtcm_cmd_addr  = sel.addr;
  assign dtcm_cmd_wdata = sel.wdata;
  assign dtcm_cmd_wmask = sel.wmask;
  assign req_cmd_ready  =
    grant & {NREQ{can_issue & dtcm_cmd_ready}};

  assign push = dtcm_cmd_valid & dtcm_cmd_ready;
  assign pop  = dtcm_rsp_valid & ~empty & ~rst;

  always_comb begin
    req_rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pop && head == IW'(i)) req_rsp_valid[i] = 1'b1;
    end
  end

  assign req_rsp_rdata  = dtcm_rsp_rdata;
  assign dtcm_rsp_ready = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_err <= 1'b0;
    end else if (dtcm_rsp_valid && empty) begin
      arb_err <= 1'b1;
    end
  end

  gnrl_fifo #(
    .DW (IW),
    .DP (OUTS_DEPTH)
  ) u_route (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (gidx),
    .pop       (pop),
    .pop_data  (head),
    .count     (cnt)
  );

endmodule
